// File: rtl/rpsc_pkg.sv
// rtl/rpsc_pkg.sv - shared types and constants for the RPSC fault latch
package rpsc_pkg;

  localparam int N_FAULT_DEFAULT  = 6;
  localparam int DEBOUNCE_DEFAULT = 16;

  typedef enum logic {
    FO_IDLE    = 1'b0,
    FO_LATCHED = 1'b1
  } fo_state_t;

  typedef logic [2:0] fo_code_t;

  localparam fo_code_t FO_NONE = 3'd0;

  // First-out code is the 1-based FF number of a 0-based channel index.
  function automatic fo_code_t fo_code_from_index(input int unsigned idx);
    return fo_code_t'(idx + 1);
  endfunction

endpackage

// File: rtl/rpsc_fault_latch_if.sv
// rtl/rpsc_fault_latch_if.sv - fault input / latch status bundle
interface rpsc_fault_latch_if #(
  parameter int N_FAULT = 6
);

  logic [N_FAULT-1:0] i_Not_Fault;
  logic               i_Not_Alarm_Reset;
  logic [N_FAULT-1:0] o_FF;
  logic [2:0]         o_First_Fault;
  logic               o_Not_Any_Fault;
  logic               o_Reset_Refused;

  // Field side: drives the raw fault lines and the operator button.
  modport master (
    output i_Not_Fault,
    output i_Not_Alarm_Reset,
    input  o_FF,
    input  o_First_Fault,
    input  o_Not_Any_Fault,
    input  o_Reset_Refused
  );

  // Latch card side.
  modport slave (
    input  i_Not_Fault,
    input  i_Not_Alarm_Reset,
    output o_FF,
    output o_First_Fault,
    output o_Not_Any_Fault,
    output o_Reset_Refused
  );

endinterface

// File: rtl/rpsc_debounce.sv
// rtl/rpsc_debounce.sv - 2-flop synchroniser plus consecutive-cycle debouncer
module rpsc_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_next_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-stage synchroniser for the asynchronous raw line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count disagreeing cycles; adopt the new level on the cycle the count reaches the limit.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and run-length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state level lets the consumer act on the same edge the level is accepted.
  assign level_next_o = level_d;

endmodule

// File: rtl/rpsc_fault_latch.sv
// rtl/rpsc_fault_latch.sv - sticky fault latches, first-out capture and operator reset
module rpsc_fault_latch
  import rpsc_pkg::*;
#(
  parameter int N_FAULT         = N_FAULT_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk,
  input  logic                Not_Reset,
  rpsc_fault_latch_if.slave   bus
);

  logic [N_FAULT-1:0] fault_n_next;
  logic [N_FAULT-1:0] fault_act;
  logic               btn_next;
  logic               btn_lvl_q;
  logic               rst_pulse;

  logic [N_FAULT-1:0] ff_q, ff_d;
  logic               refused_q, refused_d;
  fo_state_t          state_q, state_d;
  fo_code_t           code_q, code_d;
  fo_code_t           first_code;

  for (genvar k = 0; k < N_FAULT; k++) begin : g_fault
    rpsc_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1)
    ) u_fault_db (
      .clk          (clk),
      .rst_n        (Not_Reset),
      .raw_i        (bus.i_Not_Fault[k]),
      .level_next_o (fault_n_next[k])
    );
  end

  rpsc_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_button_db (
    .clk          (clk),
    .rst_n        (Not_Reset),
    .raw_i        (bus.i_Not_Alarm_Reset),
    .level_next_o (btn_next)
  );

  // Latch next-state: a reset pulse keeps only still-active faults, and a set always wins.
  always_comb begin
    fault_act = ~fault_n_next;
    rst_pulse = btn_lvl_q & ~btn_next;
    ff_d      = ff_q | fault_act;
    if (rst_pulse) begin
      ff_d = fault_act;
    end
    refused_d = rst_pulse & (|ff_d);
  end

  // Lowest set channel in the next latch vector gives the first-out candidate.
  always_comb begin
    first_code = FO_NONE;
    for (int k = N_FAULT - 1; k >= 0; k--) begin
      if (ff_d[k]) begin
        first_code = fo_code_from_index(k);
      end
    end
  end

  // First-out FSM: capture on the all-zero to non-zero step, drop only when latches are empty.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      FO_IDLE: begin
        if (|ff_d) begin
          state_d = FO_LATCHED;
          code_d  = first_code;
        end
      end
      FO_LATCHED: begin
        if (~|ff_d) begin
          state_d = FO_IDLE;
          code_d  = FO_NONE;
        end
      end
      default: begin
        state_d = FO_IDLE;
        code_d  = FO_NONE;
      end
    endcase
  end

  // Latch vector, refusal pulse, button edge history and first-out state.
  always_ff @(posedge clk or negedge Not_Reset) begin
    if (!Not_Reset) begin
      ff_q      <= '0;
      refused_q <= 1'b0;
      btn_lvl_q <= 1'b1;
      state_q   <= FO_IDLE;
      code_q    <= FO_NONE;
    end else begin
      ff_q      <= ff_d;
      refused_q <= refused_d;
      btn_lvl_q <= btn_next;
      state_q   <= state_d;
      code_q    <= code_d;
    end
  end

  assign bus.o_FF            = ff_q;
  assign bus.o_First_Fault   = code_q;
  assign bus.o_Not_Any_Fault = ~|ff_q;
  assign bus.o_Reset_Refused = refused_q;

endmodule
